// File: rtl/tlp_mux.sv
// rtl/tlp_mux.sv - two-source TLP stream multiplexer with frame locking
//
// Merges two TLP beat streams (in0_*, in1_*) onto a single registered output
// stream (out_*). A grant is issued in IDLE to a port presenting valid&sop
// when enable=1 and the output register can take a beat; the grant then locks
// the output to that port until its eop beat is accepted. Beats with sop=0
// arriving while IDLE are accepted and dropped.
//
// Ports:
//   clk, rst_n                       clock, synchronous active-low reset
//   inX_data/hdr/strb/sop/eop/valid  source X beat (X = 0, 1)
//   inX_ready                        source X beat accepted this cycle
//   out_data/hdr/strb/sop/eop/valid  registered merged stream
//   out_ready                        downstream accepts the output beat
//   enable                           permits new grants (frames in flight finish)
//
// Build option: TLP_MUX_RR_EN selects round-robin tie breaking; when
// undefined, port 0 wins every tie.
module tlp_mux #(
    parameter int DOUBLE_WORD    = 32,
    parameter int HEADER_SIZE    = 4 * DOUBLE_WORD,
    parameter int TLP_DATA_WIDTH = 8 * DOUBLE_WORD,
    parameter int TLP_STRB_WIDTH = TLP_DATA_WIDTH / 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [TLP_DATA_WIDTH-1:0] in0_data,
    input  logic [HEADER_SIZE-1:0]    in0_hdr,
    input  logic [TLP_STRB_WIDTH-1:0] in0_strb,
    input  logic                      in0_sop,
    input  logic                      in0_eop,
    input  logic                      in0_valid,
    output logic                      in0_ready,
    input  logic [TLP_DATA_WIDTH-1:0] in1_data,
    input  logic [HEADER_SIZE-1:0]    in1_hdr,
    input  logic [TLP_STRB_WIDTH-1:0] in1_strb,
    input  logic                      in1_sop,
    input  logic                      in1_eop,
    input  logic                      in1_valid,
    output logic                      in1_ready,
    output logic [TLP_DATA_WIDTH-1:0] out_data,
    output logic [HEADER_SIZE-1:0]    out_hdr,
    output logic [TLP_STRB_WIDTH-1:0] out_strb,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      out_valid,
    input  logic                      out_ready,
    input  logic                      enable
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY0 = 2'd1,
        BUSY1 = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [TLP_DATA_WIDTH-1:0] out_data_q;
    logic [HEADER_SIZE-1:0]    out_hdr_q;
    logic [TLP_STRB_WIDTH-1:0] out_strb_q;
    logic                      out_sop_q;
    logic                      out_eop_q;
    logic                      out_valid_q;

    logic out_free;
    logic req0, req1;
    logic tie0;
    logic grant0, grant1;
    logic sel0, sel1;
    logic acc0, acc1;

`ifdef TLP_MUX_RR_EN
    // Port that received the most recent grant; the other port wins a tie.
    logic last_grant_q;
    assign tie0 = last_grant_q;
`else
    assign tie0 = 1'b1;
`endif

    always_comb begin
        out_free = !out_valid_q || out_ready;
        req0     = in0_valid && in0_sop;
        req1     = in1_valid && in1_sop;
        grant0   = (state_q == IDLE) && enable && out_free && req0 && (!req1 || tie0);
        grant1   = (state_q == IDLE) && enable && out_free && req1 && !grant0;
        sel0     = (state_q == BUSY0) || grant0;
        sel1     = (state_q == BUSY1) || grant1;
        acc0     = in0_valid && sel0 && out_free;
        acc1     = in1_valid && sel1 && out_free;
        // Orphan beats (no sop) are drained while IDLE, unless the other
        // port is being granted in this same cycle.
        in0_ready = rst_n && ((sel0 && out_free) ||
                              ((state_q == IDLE) && !grant1 && in0_valid && !in0_sop));
        in1_ready = rst_n && ((sel1 && out_free) ||
                              ((state_q == IDLE) && !grant0 && in1_valid && !in1_sop));

        state_d = state_q;
        case (state_q)
            IDLE: begin
                // A single-beat TLP grants and releases in the same cycle.
                if (grant0 && !in0_eop) begin
                    state_d = BUSY0;
                end else if (grant1 && !in1_eop) begin
                    state_d = BUSY1;
                end
            end
            BUSY0: if (acc0 && in0_eop) state_d = IDLE;
            BUSY1: if (acc1 && in1_eop) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            out_data_q  <= '0;
            out_hdr_q   <= '0;
            out_strb_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef TLP_MUX_RR_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            if (acc0 || acc1) begin
                out_data_q  <= acc0 ? in0_data : in1_data;
                out_hdr_q   <= acc0 ? in0_hdr  : in1_hdr;
                out_strb_q  <= acc0 ? in0_strb : in1_strb;
                out_sop_q   <= acc0 ? in0_sop  : in1_sop;
                out_eop_q   <= acc0 ? in0_eop  : in1_eop;
                out_valid_q <= 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
`ifdef TLP_MUX_RR_EN
            if (grant0) begin
                last_grant_q <= 1'b0;
            end else if (grant1) begin
                last_grant_q <= 1'b1;
            end
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_hdr   = out_hdr_q;
    assign out_strb  = out_strb_q;
    assign out_sop   = out_sop_q;
    assign out_eop   = out_eop_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_tlp_mux.sv
// tb/tb_tlp_mux.sv - self-checking scoreboard bench for tlp_mux
module tb_tlp_mux;

    localparam int DW = 256;
    localparam int HW = 128;
    localparam int SW = 32;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [HW-1:0] hdr;
        logic [SW-1:0] strb;
        logic          sop;
        logic          eop;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] in0_data, in1_data;
    logic [HW-1:0] in0_hdr, in1_hdr;
    logic [SW-1:0] in0_strb, in1_strb;
    logic          in0_sop, in0_eop, in0_valid, in0_ready;
    logic          in1_sop, in1_eop, in1_valid, in1_ready;
    logic [DW-1:0] out_data;
    logic [HW-1:0] out_hdr;
    logic [SW-1:0] out_strb;
    logic          out_sop, out_eop, out_valid;
    logic          out_ready;
    logic          enable;

    int n_tests = 0;
    int n_fail  = 0;
    beat_t sb_q[$];
    beat_t ob;

    assign ob = {out_data, out_hdr, out_strb, out_sop, out_eop};

    tlp_mux dut (
        .clk(clk), .rst_n(rst_n),
        .in0_data(in0_data), .in0_hdr(in0_hdr), .in0_strb(in0_strb),
        .in0_sop(in0_sop), .in0_eop(in0_eop), .in0_valid(in0_valid), .in0_ready(in0_ready),
        .in1_data(in1_data), .in1_hdr(in1_hdr), .in1_strb(in1_strb),
        .in1_sop(in1_sop), .in1_eop(in1_eop), .in1_valid(in1_valid), .in1_ready(in1_ready),
        .out_data(out_data), .out_hdr(out_hdr), .out_strb(out_strb),
        .out_sop(out_sop), .out_eop(out_eop), .out_valid(out_valid),
        .out_ready(out_ready), .enable(enable)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic beat_t mk(input int p, input int id, input int b, input int n);
        beat_t   bt;
        logic [7:0] p8, id8, b8;
        p8  = p[7:0];
        id8 = id[7:0];
        b8  = b[7:0];
        bt.data = {8{p8, id8, b8, 8'h5A}};
        bt.hdr  = {4{id8, p8, 16'hC0DE}};
        bt.strb = 32'hFFFF_FFFF >> b;
        bt.sop  = (b == 0);
        bt.eop  = (b == n - 1);
        return bt;
    endfunction

    task automatic set_port(input int p, input beat_t bt, input logic v);
        if (p == 0) begin
            {in0_data, in0_hdr, in0_strb, in0_sop, in0_eop} = bt;
            in0_valid = v;
        end else begin
            {in1_data, in1_hdr, in1_strb, in1_sop, in1_eop} = bt;
            in1_valid = v;
        end
    endtask

    function automatic logic get_ready(input int p);
        return (p == 0) ? in0_ready : in1_ready;
    endfunction

    task automatic push_tlp(input int p, input int id, input int n);
        for (int b = 0; b < n; b++) sb_q.push_back(mk(p, id, b, n));
    endtask

    // Drive one n-beat TLP on port p, starting at a falling edge.
    task automatic send(input int p, input int id, input int n, input int gap);
        logic acc;
        int   cnt;
        for (int b = 0; b < n; b++) begin
            set_port(p, mk(p, id, b, n), 1'b1);
            cnt = 0;
            acc = 1'b0;
            while (!acc && cnt < 200) begin
                #1;
                acc = get_ready(p);
                @(negedge clk);
                cnt++;
            end
            check_eq("beat_accepted", 512'(acc), 512'(1));
            if (gap > 0 && b < n - 1) begin
                set_port(p, mk(p, id, b, n), 1'b0);
                repeat (gap) @(negedge clk);
            end
        end
        set_port(p, '0, 1'b0);
    endtask

    // Output monitor: compare each accepted output beat against the scoreboard.
    always begin
        @(negedge clk);
        #2;
        if (rst_n && out_valid && out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_extra_beat", 512'(ob), 512'(0));
            end else begin
                check_eq("sb_beat", 512'(ob), 512'(sb_q.pop_front()));
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        enable    = 1'b1;
        out_ready = 1'b1;
        set_port(0, mk(0, 0, 0, 2), 1'b1);
        set_port(1, '0, 1'b0);

        // Reset state, with a requesting source held off.
        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_in0_ready", 512'(in0_ready), 512'(0));
        check_eq("rst_in1_ready", 512'(in1_ready), 512'(0));
        check_eq("rst_out_valid", 512'(out_valid), 512'(0));
        check_eq("rst_out_bus",   512'(ob),        512'(0));
        @(negedge clk);
        set_port(0, '0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single port, 3 beats, one-cycle latency.
        push_tlp(0, 1, 3);
        for (int b = 0; b < 3; b++) begin
            set_port(0, mk(0, 1, b, 3), 1'b1);
            #1;
            check_eq("t1_in0_ready", 512'(in0_ready), 512'(1));
            check_eq("t1_in1_ready", 512'(in1_ready), 512'(0));
            check_eq("t1_latency",   512'(out_valid), 512'(b > 0));
            @(negedge clk);
        end
        set_port(0, '0, 1'b0);
        #1;
        check_eq("t1_last_valid", 512'(out_valid), 512'(1));
        @(negedge clk);
        #1;
        check_eq("t1_idle_valid", 512'(out_valid), 512'(0));
        @(negedge clk);

        // Tie: port 0 sends two TLPs back-to-back, port 1 one TLP.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        push_tlp(0, 2, 2);
`ifdef TLP_MUX_RR_EN
        push_tlp(1, 4, 2);
        push_tlp(0, 3, 2);
`else
        push_tlp(0, 3, 2);
        push_tlp(1, 4, 2);
`endif
        fork
            begin
                send(0, 2, 2, 0);
                send(0, 3, 2, 0);
            end
            send(1, 4, 2, 0);
        join
        @(negedge clk);

        // Backpressure for 4 cycles mid-frame.
        push_tlp(0, 5, 4);
        fork
            send(0, 5, 4, 0);
            begin
                repeat (2) @(negedge clk);
                out_ready = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    #1;
                    check_eq("bp_in0_ready", 512'(in0_ready), 512'(0));
                    check_eq("bp_out_valid", 512'(out_valid), 512'(1));
                    check_eq("bp_out_hold",  512'(ob), 512'(mk(0, 5, 1, 4)));
                    @(negedge clk);
                end
                out_ready = 1'b1;
            end
        join
        @(negedge clk);

        // In-frame valid gaps.
        push_tlp(1, 6, 3);
        send(1, 6, 3, 2);
        @(negedge clk);

        // Enable drops during port 1 beat 2 of 4.
        push_tlp(1, 7, 4);
        fork
            send(1, 7, 4, 0);
            begin
                @(negedge clk);
                enable = 1'b0;
            end
        join
        set_port(0, mk(0, 8, 0, 2), 1'b1);
        for (int i = 0; i < 4; i++) begin
            #1;
            check_eq("en_no_grant", 512'(in0_ready), 512'(0));
            @(negedge clk);
        end
        #1;
        check_eq("en_out_idle", 512'(out_valid), 512'(0));
        @(negedge clk);
        enable = 1'b1;
        push_tlp(0, 8, 2);
        send(0, 8, 2, 0);
        @(negedge clk);

        // Orphan beat in IDLE, then back-to-back single-beat TLPs.
        set_port(0, mk(0, 9, 1, 3), 1'b1);
        #1;
        check_eq("orph_ready", 512'(in0_ready), 512'(1));
        @(negedge clk);
        set_port(0, '0, 1'b0);
        #1;
        check_eq("orph_dropped", 512'(out_valid), 512'(0));
        @(negedge clk);
        for (int k = 0; k < 3; k++) push_tlp(1, 10 + k, 1);
        for (int k = 0; k < 3; k++) begin
            set_port(1, mk(1, 10 + k, 0, 1), 1'b1);
            #1;
            check_eq("sb1_ready", 512'(in1_ready), 512'(1));
            check_eq("sb1_valid", 512'(out_valid), 512'(k > 0));
            @(negedge clk);
        end
        set_port(1, '0, 1'b0);
        @(negedge clk);

        // Reset after beat 2 of a 4-beat frame.
        sb_q.push_back(mk(0, 13, 0, 4));
        for (int b = 0; b < 2; b++) begin
            set_port(0, mk(0, 13, b, 4), 1'b1);
            #1;
            check_eq("mr_ready", 512'(in0_ready), 512'(1));
            @(negedge clk);
        end
        set_port(0, mk(0, 13, 2, 4), 1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("mr_in0_ready", 512'(in0_ready), 512'(0));
        check_eq("mr_in1_ready", 512'(in1_ready), 512'(0));
        @(negedge clk);
        #1;
        check_eq("mr_out_valid", 512'(out_valid), 512'(0));
        @(negedge clk);
        set_port(0, '0, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);
        push_tlp(0, 14, 2);
        send(0, 14, 2, 0);

        for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        check_eq("sb_drain", 512'(sb_q.size()), 512'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/tlp_mux.md
TLP_MUX -- requirements
Module: tlp_mux

Interface
REQ-001 SHALL have parameter DOUBLE_WORD, default 32, meaning dword width in bits.
REQ-002 SHALL have parameter HEADER_SIZE, default 4*DOUBLE_WORD, meaning TLP header width.
REQ-003 SHALL have parameter TLP_DATA_WIDTH, default 8*DOUBLE_WORD, meaning payload beat width.
REQ-004 SHALL have parameter TLP_STRB_WIDTH, default TLP_DATA_WIDTH/8, meaning byte-strobe width.
REQ-005 SHALL have port clk, input, 1 bit: clock, all logic on rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 SHALL have ports in0_data, in0_hdr, in0_strb, in0_sop, in0_eop, in0_valid, input, with widths TLP_DATA_WIDTH, HEADER_SIZE, TLP_STRB_WIDTH, 1, 1, 1: source 0 TLP stream.
REQ-008 SHALL have port in0_ready, output, 1 bit: source 0 beat accepted when in0_valid and in0_ready are both high.
REQ-009 SHALL have ports in1_data, in1_hdr, in1_strb, in1_sop, in1_eop, in1_valid, input, and in1_ready, output, with the same widths as source 0: source 1 TLP stream.
REQ-010 SHALL have ports out_data, out_hdr, out_strb, out_sop, out_eop, out_valid, output, all registered, with the same widths: merged TLP stream.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts the beat.
REQ-012 SHALL have port enable, input, 1 bit: permits new grants.

Function
REQ-013 SHALL implement an FSM with states IDLE, BUSY0 and BUSY1.
- IDLE->BUSYi: on a grant to port i.
- BUSYi->IDLE: when the eop beat of port i is accepted.
REQ-014 SHALL grant in IDLE only when enable=1, the candidate port presents valid&sop, and the output stage can accept a beat.
- The grant SHALL take effect in the same cycle; the sop beat is accepted in the grant cycle.
REQ-015 SHALL arbitrate as follows: only one port requesting wins; if both request, the winner is given by REQ-031/REQ-032.
REQ-016 SHALL drive ini_ready = (state selects i, or IDLE grant to i) & (!out_valid | out_ready); the non-granted port's ready SHALL be 0.
REQ-017 SHALL, while in IDLE, accept and discard a beat with valid=1, sop=0 (ready=1, nothing output).
REQ-018 SHALL, while in IDLE, never emit a discarded beat; a beat in BUSYi with sop=1 SHALL be forwarded unchanged, with no re-check.
REQ-019 SHALL register accepted beats to out_* with 1-cycle latency, keeping data, hdr, strb, sop and eop of the same beat aligned.
REQ-020 SHALL hold out_* stable while out_valid=1 and out_ready=0, and clear out_valid after acceptance unless a new beat loads in the same cycle.
REQ-021 SHALL sustain one beat per cycle when out_ready is held at 1.
REQ-022 SHALL treat a single-beat TLP (sop=eop=1) as grant and release in one cycle, with a new grant possible the next cycle.
REQ-023 SHALL never interleave two TLPs: the lock holds from sop to eop irrespective of the other port.
REQ-024 SHALL not affect an in-progress frame when enable drops; the FSM SHALL return to IDLE at eop and issue no new grant while enable=0.
REQ-025 SHALL tolerate in-frame valid gaps, remaining in BUSYi.

Reset
REQ-026 SHALL, with rst_n=0 at a clk edge, reset the FSM to IDLE.
REQ-027 SHALL reset out_data, out_hdr, out_strb, out_sop, out_eop and out_valid to 0.
REQ-028 SHALL hold in0_ready=0 and in1_ready=0 throughout reset.
REQ-029 SHALL reset last_grant to 1, so port 0 wins the first tie.
REQ-030 SHALL, on reset mid-frame, abandon the partial frame with no eop emitted; upstream is responsible for re-framing.

Configuration
REQ-031 SHALL, when TLP_MUX_RR_EN is defined, arbitrate a tie by round-robin: the port not equal to last_grant wins, and last_grant updates on each grant.
REQ-032 SHALL, when TLP_MUX_RR_EN is undefined, arbitrate a tie by fixed priority with port 0 winning, and SHALL not implement the last_grant register.

Verification
REQ-033 SHALL cover single port: in0 sends a 3-beat TLP, out_ready=1 -> out shows 3 beats, sop on beat 1, eop on beat 3, 1-cycle latency, in1_ready=0 throughout.
REQ-034 SHALL cover a tie: both ports present a 2-beat TLP at cycle 0 -> with RR, port 0 then port 1; without RR, port 0 first; in both cases no interleave.
REQ-035 SHALL cover backpressure: out_ready=0 for 4 cycles mid-frame -> out_* stable, in0_ready=0, and no beat lost or duplicated after release.
REQ-036 SHALL cover enable: enable falls during in1 beat 2 of 4 -> all 4 beats are output, then no grant until enable=1.
REQ-037 SHALL cover orphan/single-beat traffic: in0 beat with sop=0 in IDLE -> discarded and not output; back-to-back single-beat TLPs from in1 -> one per cycle.
REQ-038 SHALL cover reset mid-frame: rst_n=0 after beat 2 -> out_valid=0, both readies=0, then IDLE, and a fresh TLP passes cleanly.
